ddc_ctrl: RTL and testbench

DDC_CTRL -- requirements
Module: ddc_ctrl

---
 rtl/ddc_ctrl_pkg.sv | 23 ++
 rtl/ddc_ctrl_timer.sv | 30 +++
 rtl/ddc_ctrl.sv | 150 +++++++++++++++
 tb/tb_ddc_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddc_ctrl_pkg.sv
// DDC control shared definitions: FSM state encoding,
// default DDS phase increment, dropout counter width.
package ddc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_CFG,
    S_SETTLE,
    S_WAIT_LOCK,
    S_RUN,
    S_FAULT
  } state_t;

  // 50 MHz IF at 200 MHz sample rate
  localparam logic [31:0] PINC_DEFAULT = 32'h4000_0000;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddc_ctrl_timer.sv
// Loadable down-counter shared by the SETTLE and WAIT_LOCK phases.
// Ports: clk, reset (sync, high), i_load/i_value load, o_done when zero.
module ddc_ctrl_timer
  import ddc_ctrl_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Loading N-1 makes a phase last exactly N cycles
  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ddc_ctrl.sv
// DDC controller: configures the DDS phase increment, holds the DDC
// in reset while it settles, waits for lock and tracks input dropouts.
// Ports: clk/reset; retune_* request; cfg_* AXI-S to DDS config;
// dds_val/adc_val/iq_val status; ddc_reset, locked, fault, dropout_cnt.
module ddc_ctrl #(
  parameter logic [31:0] PINC_DEFAULT = ddc_ctrl_pkg::PINC_DEFAULT,
  parameter int          SETTLE_CYC   = 16,
  parameter int          LOCK_TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            retune_valid,
  input  logic [31:0]                     retune_pinc,
  output logic                            retune_ready,
  output logic [31:0]                     cfg_tdata,
  output logic                            cfg_tvalid,
  input  logic                            cfg_tready,
  input  logic                            dds_val,
  input  logic                            adc_val,
  input  logic                            iq_val,
  output logic                            ddc_reset,
  output logic                            locked,
  output logic                            fault,
  output logic [ddc_ctrl_pkg::DROP_W-1:0] dropout_cnt
);

  import ddc_ctrl_pkg::*;

  localparam int TW =
    $clog2(max_int(SETTLE_CYC, LOCK_TIMEOUT) + 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD   = TW'(LOCK_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_pinc;
  logic              r_cfg_tvalid;
  logic              r_ddc_reset;
  logic              r_locked;
  logic              r_fault;
  logic              r_ready;
  logic [DROP_W-1:0] r_drop;

  logic              w_accept;
  logic              w_hs;
  logic              w_dropout;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_done;
  logic              w_cfg_tvalid;
  logic              w_ddc_reset;
  logic              w_locked;
  logic              w_fault;
  logic              w_ready;

  // r_ready mirrors RUN/FAULT, so this only fires in those states
  assign w_accept  = retune_valid & r_ready;
  // r_cfg_tvalid is low the first CFG cycle after reset
  assign w_hs      = r_cfg_tvalid & cfg_tready;
  assign w_dropout = (r_state == S_RUN) & ~(dds_val & adc_val);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CFG: begin
        if (w_hs) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_tmr_done) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (iq_val) w_next = S_RUN;
        else if (w_tmr_done) w_next = S_FAULT;
      end
      S_RUN: begin
        if (w_accept) w_next = S_CFG;
        else if (w_dropout) w_next = S_SETTLE;
      end
      S_FAULT: begin
        if (w_accept) w_next = S_CFG;
      end
      default: w_next = S_CFG;
    endcase

    // Outputs are registered from the next state so they
    // line up with the state they describe.
    w_cfg_tvalid = (w_next == S_CFG);
    w_ddc_reset  = (w_next == S_CFG) ||
                   (w_next == S_SETTLE) ||
                   (w_next == S_FAULT);
    w_locked     = (w_next == S_RUN);
    w_fault      = (w_next == S_FAULT);
    w_ready      = (w_next == S_RUN) || (w_next == S_FAULT);

    w_tmr_load = (w_next != r_state) &&
                 ((w_next == S_SETTLE) ||
                  (w_next == S_WAIT_LOCK));
    w_tmr_val  = (w_next == S_SETTLE) ? SETTLE_LD : LOCK_LD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CFG;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pinc       <= PINC_DEFAULT;
      r_cfg_tvalid <= 1'b0;
      r_ddc_reset  <= 1'b1;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_ready      <= 1'b0;
      r_drop       <= '0;
    end else begin
      if (w_accept) r_pinc <= retune_pinc;
      r_cfg_tvalid <= w_cfg_tvalid;
      r_ddc_reset  <= w_ddc_reset;
      r_locked     <= w_locked;
      r_fault      <= w_fault;
      r_ready      <= w_ready;
      // counts even when a retune wins the same cycle
      if (w_dropout && (r_drop != DROP_MAX)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  ddc_ctrl_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_value(w_tmr_val),
    .o_done (w_tmr_done)
  );

  assign cfg_tdata    = r_pinc;
  assign cfg_tvalid   = r_cfg_tvalid;
  assign ddc_reset    = r_ddc_reset;
  assign locked       = r_locked;
  assign fault        = r_fault;
  assign retune_ready = r_ready;
  assign dropout_cnt  = r_drop;

endmodule

// File: tb/tb_ddc_ctrl.sv
// Directed bench for ddc_ctrl: vector table plus
// hand sequences for timeout, backpressure and saturation.
module tb_ddc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        retune_valid;
  logic [31:0] retune_pinc;
  logic        retune_ready;
  logic [31:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic        dds_val;
  logic        adc_val;
  logic        iq_val;
  logic        ddc_reset;
  logic        locked;
  logic        fault;
  logic [7:0]  dropout_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .retune_valid(retune_valid),
    .retune_pinc (retune_pinc),
    .retune_ready(retune_ready),
    .cfg_tdata   (cfg_tdata),
    .cfg_tvalid  (cfg_tvalid),
    .cfg_tready  (cfg_tready),
    .dds_val     (dds_val),
    .adc_val     (adc_val),
    .iq_val      (iq_val),
    .ddc_reset   (ddc_reset),
    .locked      (locked),
    .fault       (fault),
    .dropout_cnt (dropout_cnt)
  );

  typedef struct {
    int          n;
    logic        rst;
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    logic        dv;
    logic        av;
    logic        iq;
    logic        tv;
    logic [31:0] td;
    logic        dr;
    logic        lk;
    logic        ft;
    logic        rr;
    logic [7:0]  dc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input int n, input logic rst, input logic rv,
    input logic [31:0] rp, input logic rdy, input logic dv,
    input logic av, input logic iq, input logic tv,
    input logic [31:0] td, input logic dr, input logic lk,
    input logic ft, input logic rr, input logic [7:0] dc);
    vec_t v;
    v.n = n; v.rst = rst; v.rv = rv; v.rp = rp;
    v.rdy = rdy; v.dv = dv; v.av = av; v.iq = iq;
    v.tv = tv; v.td = td; v.dr = dr; v.lk = lk;
    v.ft = ft; v.rr = rr; v.dc = dc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] P0 = 32'h4000_0000;
  localparam logic [31:0] P1 = 32'h1234_5678;
  localparam logic [31:0] P2 = 32'hDEAD_BEEF;
  localparam logic [31:0] P3 = 32'h2000_0000;

  initial begin
    reset = 1'b1; retune_valid = 1'b0; retune_pinc = '0;
    cfg_tready = 1'b0; dds_val = 1'b0; adc_val = 1'b0;
    iq_val = 1'b0;

    //                n  rs rv rp  rdy dv av iq  tv td  dr lk ft rr dc
    vecs.push_back(mk(2, 1, 0, 0,  1, 1, 1, 1,  0, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  1, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  0, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(15,0, 0, 0,  1, 1, 1, 1,  0, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  0, P0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  0, P0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, P1, 0, 1, 0, 1,  1, P1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(3, 0, 1, P2, 0, 1, 1, 1,  1, P1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  0, P1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(5, 0, 0, 0,  1, 1, 1, 1,  0, P1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0,  1, 1, 1, 1,  0, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1,  1, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 1, 1, 1,  1, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,  1, 1, 1, 1,  0, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  1, P0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, 1, 1, 1,  0, P0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      retune_valid = vecs[i].rv;
      retune_pinc = vecs[i].rp;
      cfg_tready = vecs[i].rdy;
      dds_val = vecs[i].dv;
      adc_val = vecs[i].av;
      iq_val = vecs[i].iq;
      step(vecs[i].n);
      chk($sformatf("v%0d.cfg_tvalid", i), 32'(cfg_tvalid), 32'(vecs[i].tv));
      chk($sformatf("v%0d.cfg_tdata", i), cfg_tdata, vecs[i].td);
      chk($sformatf("v%0d.ddc_reset", i), 32'(ddc_reset), 32'(vecs[i].dr));
      chk($sformatf("v%0d.locked", i), 32'(locked), 32'(vecs[i].lk));
      chk($sformatf("v%0d.fault", i), 32'(fault), 32'(vecs[i].ft));
      chk($sformatf("v%0d.ready", i), 32'(retune_ready), 32'(vecs[i].rr));
      chk($sformatf("v%0d.dropout", i), 32'(dropout_cnt), 32'(vecs[i].dc));
    end

    // lock timeout into FAULT, then retune out of it
    iq_val = 1'b0;
    step(15);
    chk("to.settle_end", 32'(ddc_reset), 32'd1);
    step(1);
    chk("to.wl_first", 32'(ddc_reset), 32'd0);
    step(1023);
    chk("to.wl_last.fault", 32'(fault), 32'd0);
    chk("to.wl_last.ddc_reset", 32'(ddc_reset), 32'd0);
    step(1);
    chk("to.fault", 32'(fault), 32'd1);
    chk("to.ddc_reset", 32'(ddc_reset), 32'd1);
    chk("to.ready", 32'(retune_ready), 32'd1);
    chk("to.locked", 32'(locked), 32'd0);
    retune_valid = 1'b1;
    retune_pinc = P3;
    step(1);
    retune_valid = 1'b0;
    cfg_tready = 1'b0;
    chk("rt.cfg_tdata", cfg_tdata, P3);
    chk("rt.fault", 32'(fault), 32'd0);
    chk("rt.cfg_tvalid", 32'(cfg_tvalid), 32'd1);
    chk("rt.ready", 32'(retune_ready), 32'd0);

    // backpressure: valid/data held while ready is low
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk($sformatf("bp%0d.cfg_tvalid", k), 32'(cfg_tvalid), 32'd1);
      chk($sformatf("bp%0d.cfg_tdata", k), cfg_tdata, P3);
    end
    cfg_tready = 1'b1;
    step(1);
    chk("bp.settle.cfg_tvalid", 32'(cfg_tvalid), 32'd0);
    chk("bp.settle.ddc_reset", 32'(ddc_reset), 32'd1);
    iq_val = 1'b1;
    step(15);
    chk("bp.settle_end", 32'(ddc_reset), 32'd1);
    step(1);
    chk("bp.wl", 32'(ddc_reset), 32'd0);
    step(1);
    chk("bp.run", 32'(locked), 32'd1);

    // repeated dropouts: counter saturates, each restarts SETTLE
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 1) dds_val = 1'b0;
      else adc_val = 1'b0;
      step(1);
      dds_val = 1'b1;
      adc_val = 1'b1;
      chk($sformatf("dr%0d.cnt", k), 32'(dropout_cnt),
          (k + 1 > 255) ? 32'd255 : 32'(k + 1));
      chk($sformatf("dr%0d.unlock", k), 32'(locked), 32'd0);
      step(16);
      step(1);
      chk($sformatf("dr%0d.relock", k), 32'(locked), 32'd1);
    end
    chk("dr.final", 32'(dropout_cnt), 32'd255);
    chk("dr.ready", 32'(retune_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
